// File: rtl/gr_pkg.sv
// Shared types and constants for the general-register file and its pending-write scoreboard.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Defaults here match the core's standard configuration.
package gr_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  // Register 0 is hard-wired: reads 0, never busy, writes dropped.
  localparam reg_idx_t ZERO_REG = '0;

  // Largest number of in-flight producers a counter of this width can track.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/gr_pend_ctr.sv
// Purpose: per-register in-flight producer counter (issue increments, write-back decrements).
// Latency: count updates at the next edge; status outputs are combinational from the stored count.
// Backpressure: none internally; at_max lets the top refuse issue, and the count saturates rather than wrap.
module gr_pend_ctr
  import gr_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic at_max,
  output logic is_one,
  output logic uflow_pulse
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: simultaneous inc/dec cancel (never an underflow); a lone dec at 0 holds and flags.
  always_comb begin
    cnt_d       = cnt_q;
    uflow_pulse = 1'b0;
    if (inc && !dec) begin
      if (cnt_q != MAX) cnt_d = cnt_q + ONE;
    end else if (dec && !inc) begin
      if (cnt_q == '0) uflow_pulse = 1'b1;
      else             cnt_d       = cnt_q - ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign nonzero = (cnt_q != '0);
  assign at_max  = (cnt_q == MAX);
  assign is_one  = (cnt_q == ONE);

endmodule

// File: rtl/gr_sb.sv
// Purpose: general-register file with N_RD read ports, one write-back port and a pending-write scoreboard.
// Latency: reads, rbusy and iss_ready are combinational; writes, counters and err_uflow update at the next edge.
// Backpressure: iss_ready drops when the destination counter is full, unless a same-cycle write-back retires one.
module gr_sb
  import gr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = 3,
  parameter int CNT_W  = DEF_CNT_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [N_RD*ADDR_W-1:0] raddr,
  output logic [N_RD*DATA_W-1:0] rdata,
  output logic [N_RD-1:0]        rbusy,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   iss_ready,
  output logic                   err_uflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  // Entry 0 is kept at 0 and never written, so it folds away in synthesis.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              err_q, err_d;

  logic [DEPTH-1:0] cnt_nz, cnt_max_v, cnt_one, cnt_uf;

  logic wr_en;
  logic iss_acc;

  assign wr_en   = we && (waddr != ZERO);
  assign iss_acc = iss_valid && iss_ready && (iss_addr != ZERO);

  // Register 0 has no counter: never busy, never full, never underflows.
  assign cnt_nz[0]    = 1'b0;
  assign cnt_max_v[0] = 1'b0;
  assign cnt_one[0]   = 1'b0;
  assign cnt_uf[0]    = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
    gr_pend_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk         (clk),
      .reset       (reset),
      .inc         (iss_acc && (iss_addr == ADDR_W'(r))),
      .dec         (wr_en && (waddr == ADDR_W'(r))),
      .nonzero     (cnt_nz[r]),
      .at_max      (cnt_max_v[r]),
      .is_one      (cnt_one[r]),
      .uflow_pulse (cnt_uf[r])
    );
  end

  // A full destination blocks issue unless the same cycle's write-back frees a slot.
  always_comb begin
    iss_ready = !(cnt_max_v[iss_addr] && !(we && (waddr == iss_addr)));
  end

  // Write-back into the array and accumulate the sticky underflow flag.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
    err_d = err_q | (|cnt_uf);
  end

  // Architectural state with synchronous reset taking priority over any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  assign err_uflow = err_q;

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    assign ra  = raddr[k*ADDR_W +: ADDR_W];
    assign fwd = BYPASS && we && (waddr == ra);
    assign rdata[k*DATA_W +: DATA_W] = (ra == ZERO) ? '0 : (fwd ? wdata : regs_q[ra]);
    // The last outstanding producer writing back this cycle clears busy when forwarding.
    assign rbusy[k] = (ra != ZERO) && cnt_nz[ra] && !(fwd && cnt_one[ra]);
  end

endmodule

// File: tb/tb_gr_sb.sv
// Self-checking bench for gr_sb: directed scenarios then randomized traffic against a behavioural model.
// Each step drives inputs on the falling edge, checks combinational outputs shortly after, then steps the model.
// Model state: plain arrays of register values and integer in-flight counts plus a sticky error bit.
module tb_gr_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              iss_ready;
  logic              err_uflow;

  always #5 clk = ~clk;

  gr_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .CNT_W(CW), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .err_uflow(err_uflow)
  );

  // Reference model
  logic [DW-1:0] m_reg [32];
  int            m_cnt [32];
  bit            m_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic int rnd_idx();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 7));
  endfunction

  // One clock of stimulus: drive, check outputs against the model, advance the model.
  task automatic step(input bit rst, input bit w, input int wa, input logic [DW-1:0] wd,
                      input int r0, input int r1, input int r2, input bit iv, input int ia);
    int          ra [NR];
    logic [DW-1:0] exp_d;
    bit          exp_b;
    bit          exp_rdy;
    bit          acc, wr;
    @(negedge clk);
    reset     = rst;
    we        = w;
    waddr     = AW'(wa);
    wdata     = wd;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    raddr     = {AW'(r2), AW'(r1), AW'(r0)};
    iss_valid = iv;
    iss_addr  = AW'(ia);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (ra[k] == 0)                  exp_d = '0;
      else if (w && wa == ra[k])       exp_d = wd;
      else                             exp_d = m_reg[ra[k]];
      exp_b = (ra[k] != 0) && (m_cnt[ra[k]] != 0) && !(w && wa == ra[k] && m_cnt[ra[k]] == 1);
      chk($sformatf("rdata%0d@r%0d", k, ra[k]), 64'(rdata[k*DW +: DW]), 64'(exp_d));
      chk($sformatf("rbusy%0d@r%0d", k, ra[k]), 64'(rbusy[k]), 64'(exp_b));
    end
    exp_rdy = (ia == 0) || !(m_cnt[ia] == CMAX && !(w && wa == ia));
    chk($sformatf("iss_ready@r%0d", ia), 64'(iss_ready), 64'(exp_rdy));
    chk("err_uflow", 64'(err_uflow), 64'(m_err));
    // State the model holds after the coming edge
    if (rst) begin
      model_clear();
    end else begin
      acc = iv && exp_rdy && ia != 0;
      wr  = w && wa != 0;
      if (wr) m_reg[wa] = wd;
      if (!(acc && wr && ia == wa)) begin
        if (acc) m_cnt[ia]++;
        if (wr) begin
          if (m_cnt[wa] == 0) m_err = 1'b1;
          else                m_cnt[wa]--;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    iss_valid = 1'b0; iss_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);

    // 1: post-reset state, issue to reg 0 has no effect
    step(0, 0, 0, 0, 5, 5, 5, 1, 0);
    step(0, 0, 0, 0, 0, 5, 0, 0, 0);

    // 2: issue r7, busy next cycle, bypassed write clears busy and forwards data
    step(0, 0, 0, 0, 7, 7, 7, 1, 7);
    step(0, 0, 0, 0, 7, 1, 2, 0, 7);
    step(0, 1, 7, 32'hDEADBEEF, 7, 7, 0, 0, 0);
    step(0, 0, 0, 0, 7, 0, 0, 0, 0);

    // 3: fill r3, full blocks issue, write-back same cycle re-opens it and count stays full
    repeat (3) step(0, 0, 0, 0, 3, 0, 0, 1, 3);
    step(0, 0, 0, 0, 3, 3, 3, 1, 3);
    step(0, 1, 3, 32'h0000_3333, 3, 0, 0, 1, 3);
    step(0, 0, 0, 0, 3, 0, 0, 0, 3);

    // 4: write-back with no producer outstanding sets the sticky error
    step(0, 1, 9, 32'h0909_0909, 9, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 9, 3, 7, 0, 0);

    // 5: issue and write-back together at count 0 is not an underflow
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 32'h4444_4444, 4, 0, 0, 1, 4);
    step(0, 0, 0, 0, 4, 4, 0, 0, 4);

    // 6: reset with r2 pending twice and a write in flight discards everything
    step(0, 0, 0, 0, 2, 0, 0, 1, 2);
    step(0, 0, 0, 0, 2, 0, 0, 1, 2);
    step(1, 1, 2, 32'h2222_2222, 2, 4, 0, 1, 2);
    step(0, 0, 0, 0, 2, 4, 0, 0, 2);

    // Randomized traffic focused on a few registers so counters saturate and collide
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 4, rnd_idx(), $urandom(),
           rnd_idx(), rnd_idx(), rnd_idx(),
           $urandom_range(0, 1) == 1, rnd_idx());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
